// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the instruction loader.
// master drives the byte stream and observes writes; slave is the loader itself.
interface instr_mem_loader_if #(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned NB_INSTR = 32,
  parameter int unsigned NB_ADDR  = 10
) ();

  logic [NB_DATA-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                o_wr_en;
  logic [NB_ADDR-1:0]  o_wr_addr;
  logic [NB_INSTR-1:0] o_wr_data;

  modport master (
    output i_rx_data,
    output i_rx_valid,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_valid,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data
  );

endinterface

// File: rtl/instr_mem_loader.sv
// Assembles little-endian instruction words from a UART byte stream and writes them to
// instruction memory. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_mem_loader #(
  parameter int unsigned         NB_DATA   = 8,
  parameter int unsigned         NB_INSTR  = 32,
  parameter int unsigned         NB_ADDR   = 10,
  parameter logic [NB_INSTR-1:0] HALT_WORD = {NB_INSTR{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  instr_mem_loader_if.slave   bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [NB_ADDR-1:0]  o_instr_count,
  output logic                o_chk_err
);

  localparam int unsigned Lanes = NB_INSTR / NB_DATA;
  localparam int unsigned ByteW = $clog2(Lanes);
  localparam logic [ByteW-1:0]   ByteLast = ByteW'(Lanes - 1);
  // Byte address of the last word slot in memory.
  localparam logic [NB_ADDR-1:0] AddrLast = {NB_ADDR{1'b1}} ^ NB_ADDR'(Lanes - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRecv  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck = 3'd3;
`endif
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [ByteW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [NB_INSTR-1:0] word_q, word_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_ADDR-1:0]  count_q, count_d;
  logic                overflow_q, overflow_d;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_DATA-1:0]  xor_q, xor_d;
  logic                chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    chk_err_d  = chk_err_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d    = StRecv;
          byte_cnt_d = '0;
          addr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = '0;
          chk_err_d  = 1'b0;
`endif
        end
      end

      StRecv: begin
        if (bus.i_rx_valid) begin
          for (int unsigned i = 0; i < Lanes; i++) begin
            if (ByteW'(i) == byte_cnt_q) begin
              word_d[i*NB_DATA +: NB_DATA] = bus.i_rx_data;
            end
          end
          byte_cnt_d = byte_cnt_q + ByteW'(1);
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.i_rx_data;
`endif
          if (byte_cnt_q == ByteLast) begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        count_d = count_q + NB_ADDR'(1);
        if (word_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
          // A byte arriving alongside the halt write is already the checksum.
          if (bus.i_rx_valid) begin
            state_d   = StDone;
            chk_err_d = (bus.i_rx_data != xor_q);
          end else begin
            state_d = StCheck;
          end
`else
          state_d = StDone;
`endif
        end else if (addr_q == AddrLast) begin
          state_d    = StDone;
          overflow_d = 1'b1;
        end else begin
          state_d = StRecv;
          addr_d  = addr_q + NB_ADDR'(Lanes);
          // Keep a byte that lands on the write cycle as lane 0 of the next word.
          if (bus.i_rx_valid) begin
            word_d[NB_DATA-1:0] = bus.i_rx_data;
            byte_cnt_d          = ByteW'(1);
`ifdef LOADER_CHECKSUM_EN
            xor_d               = xor_q ^ bus.i_rx_data;
`endif
          end else begin
            byte_cnt_d = '0;
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (bus.i_rx_valid) begin
          state_d   = StDone;
          chk_err_d = (bus.i_rx_data != xor_q);
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  always_comb begin
    bus.o_wr_en   = (state_q == StWrite);
    bus.o_wr_addr = addr_q;
    bus.o_wr_data = bus.o_wr_en ? word_q : '0;
    o_done        = (state_q == StDone);
    o_busy        = (state_q == StRecv) || (state_q == StWrite)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == StCheck)
`endif
                    ;
    o_overflow    = overflow_q;
    o_instr_count = count_q;
`ifdef LOADER_CHECKSUM_EN
    o_chk_err     = chk_err_q;
`else
    o_chk_err     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a default-size instance and a 16-byte-memory
// instance for the overflow case. Expected writes are queued; monitors pop on o_wr_en.
module tb_instr_mem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  logic start_m, start_s;
  logic busy_m, done_m, ovf_m, chk_m;
  logic busy_s, done_s, ovf_s, chk_s;
  logic [9:0] cnt_m;
  logic [3:0] cnt_s;

  int checks = 0;
  int errors = 0;
  wr_t q_m[$];
  wr_t q_s[$];
  wr_t em, es;

  instr_mem_loader_if #(.NB_ADDR(10)) if_m ();
  instr_mem_loader_if #(.NB_ADDR(4))  if_s ();

  instr_mem_loader #(.NB_ADDR(10)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start_m),
    .bus           (if_m.slave),
    .o_busy        (busy_m),
    .o_done        (done_m),
    .o_overflow    (ovf_m),
    .o_instr_count (cnt_m),
    .o_chk_err     (chk_m)
  );

  instr_mem_loader #(.NB_ADDR(4)) u_small (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start_s),
    .bus           (if_s.slave),
    .o_busy        (busy_s),
    .o_done        (done_s),
    .o_overflow    (ovf_s),
    .o_instr_count (cnt_s),
    .o_chk_err     (chk_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_m.o_wr_en === 1'b1) begin
      checks++;
      if (q_m.size() == 0) begin
        errors++;
        $display("FAIL wr_main unexpected write addr=%h data=%h", if_m.o_wr_addr,
                 if_m.o_wr_data);
      end else begin
        em = q_m.pop_front();
        if (32'(if_m.o_wr_addr) !== em.addr || if_m.o_wr_data !== em.data) begin
          errors++;
          $display("FAIL wr_main actual addr=%h data=%h required addr=%h data=%h",
                   if_m.o_wr_addr, if_m.o_wr_data, em.addr, em.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_s.o_wr_en === 1'b1) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL wr_small unexpected write addr=%h data=%h", if_s.o_wr_addr,
                 if_s.o_wr_data);
      end else begin
        es = q_s.pop_front();
        if (32'(if_s.o_wr_addr) !== es.addr || if_s.o_wr_data !== es.data) begin
          errors++;
          $display("FAIL wr_small actual addr=%h data=%h required addr=%h data=%h",
                   if_s.o_wr_addr, if_s.o_wr_data, es.addr, es.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit sel, input bit st, input bit vld, input logic [7:0] d);
    if (sel) begin
      start_s = st; if_s.i_rx_valid = vld; if_s.i_rx_data = d;
    end else begin
      start_m = st; if_m.i_rx_valid = vld; if_m.i_rx_data = d;
    end
    @(posedge clk);
    #1;
    start_m = 1'b0; start_s = 1'b0;
    if_m.i_rx_valid = 1'b0; if_s.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) cyc(sel, 1'b0, 1'b1, w[8*i +: 8]);
  endtask

  task automatic exp_m(input logic [31:0] a, input logic [31:0] d);
    q_m.push_back('{addr: a, data: d});
  endtask

  task automatic exp_s(input logic [31:0] a, input logic [31:0] d);
    q_s.push_back('{addr: a, data: d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_m = 1'b0; start_s = 1'b0;
    if_m.i_rx_valid = 1'b0; if_m.i_rx_data = '0;
    if_s.i_rx_valid = 1'b0; if_s.i_rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", 32'(if_m.o_wr_en), 32'd0);
    chk("reset_busy", 32'(busy_m), 32'd0);
    chk("reset_done", 32'(done_m), 32'd0);
    chk("reset_count", 32'(cnt_m), 32'd0);
    chk("reset_addr", 32'(if_m.o_wr_addr), 32'd0);
    rst = 1'b0;

    // Single word, then back to receiving.
    cyc(0, 1'b1, 1'b0, 8'h00);
    exp_m(32'h000, 32'h0050_0513);
    send_word(0, 32'h0050_0513);
    cyc(0, 1'b0, 1'b0, 8'h00);
    chk("t1_count", 32'(cnt_m), 32'd1);
    chk("t1_busy", 32'(busy_m), 32'd1);
    chk("t1_done", 32'(done_m), 32'd0);

    // Halt word ends the load.
    exp_m(32'h004, 32'hFFFF_FFFF);
    send_word(0, 32'hFFFF_FFFF);
    cyc(0, 1'b0, 1'b0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    chk("t2_check_busy", 32'(busy_m), 32'd1);
    chk("t2_check_done", 32'(done_m), 32'd0);
    cyc(0, 1'b0, 1'b1, 8'h46);
`endif
    chk("t2_done", 32'(done_m), 32'd1);
    chk("t2_busy", 32'(busy_m), 32'd0);
    chk("t2_count", 32'(cnt_m), 32'd2);
    chk("t2_overflow", 32'(ovf_m), 32'd0);
    chk("t2_addr_hold", 32'(if_m.o_wr_addr), 32'h004);
    chk("t2_chk_err", 32'(chk_m), 32'd0);
    send_word(0, 32'h1234_5678);
    cyc(0, 1'b0, 1'b0, 8'h00);
    chk("t2_done_ignores_rx", 32'(cnt_m), 32'd2);

    // Restart from DONE; fifth byte arrives during the write cycle.
    cyc(0, 1'b1, 1'b0, 8'h00);
    chk("t3_restart_count", 32'(cnt_m), 32'd0);
    exp_m(32'h000, 32'h4433_2211);
    exp_m(32'h004, 32'hEEDD_CCAB);
    send_word(0, 32'h4433_2211);
    send_word(0, 32'hEEDD_CCAB);
    cyc(0, 1'b0, 1'b0, 8'h00);
    chk("t3_count", 32'(cnt_m), 32'd2);
    chk("t3_busy", 32'(busy_m), 32'd1);

    // Reset mid-word aborts without a write.
    cyc(0, 1'b1, 1'b0, 8'h00);
    cyc(0, 1'b0, 1'b1, 8'hA1);
    cyc(0, 1'b0, 1'b1, 8'hA2);
    rst = 1'b1;
    #2;
    chk("t4_rst_wr_en", 32'(if_m.o_wr_en), 32'd0);
    chk("t4_rst_busy", 32'(busy_m), 32'd0);
    chk("t4_rst_count", 32'(cnt_m), 32'd0);
    chk("t4_rst_addr", 32'(if_m.o_wr_addr), 32'd0);
    chk("t4_rst_data", if_m.o_wr_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 1'b1, 1'b0, 8'h00);
    exp_m(32'h000, 32'h1234_5678);
    send_word(0, 32'h1234_5678);
    cyc(0, 1'b0, 1'b0, 8'h00);
    chk("t4_count", 32'(cnt_m), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1'b1, 1'b0, 8'h00);
      exp_m(32'h000, 32'h0000_0001);
      exp_m(32'h004, 32'hFFFF_FFFF);
      send_word(0, 32'h0000_0001);
      send_word(0, 32'hFFFF_FFFF);
      cyc(0, 1'b0, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, (k == 0) ? 8'h01 : 8'h02);
      chk("t5_done", 32'(done_m), 32'd1);
      chk("t5_chk_err", 32'(chk_m), (k == 0) ? 32'd0 : 32'd1);
    end
`endif

    // 16-byte memory fills before any halt word.
    cyc(1, 1'b1, 1'b0, 8'h00);
    for (int w = 0; w < 4; w++) begin
      exp_s(32'(4 * w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      for (int b = 0; b < 4; b++) cyc(1, 1'b0, 1'b1, 8'(4 * w + b));
    end
    cyc(1, 1'b0, 1'b0, 8'h00);
    chk("t6_done", 32'(done_s), 32'd1);
    chk("t6_overflow", 32'(ovf_s), 32'd1);
    chk("t6_count", 32'(cnt_s), 32'd4);
    chk("t6_addr", 32'(if_s.o_wr_addr), 32'hC);
    chk("t6_chk_err", 32'(chk_s), 32'd0);
    send_word(1, 32'h0403_0201);
    cyc(1, 1'b0, 1'b0, 8'h00);
    chk("t6_count_hold", 32'(cnt_s), 32'd4);

    repeat (3) cyc(0, 1'b0, 1'b0, 8'h00);
    chk("main_queue_empty", 32'(q_m.size()), 32'd0);
    chk("small_queue_empty", 32'(q_s.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
